exec_datapath: RTL and testbench
================================

EXEC_DATAPATH -- requirements
Module: exec_datapath

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all registered state immediately.
REQ-004 base_address  in  32  AGU base operand.
REQ-005 immediate  in  16  AGU displacement, signed.
REQ-006 immediate_mode  in  1  1 = AGU adds immediate; 0 = AGU adds register_data.
REQ-007 register_data  in  32  AGU register displacement.
REQ-008 program_counter  in  32  instruction fetch address.
REQ-009 memory_access_cycle  in  1  1 = data access using agu_result; 0 = instruction fetch.
REQ-010 memory_read, memory_write  in  1 each  data-cycle direction.
REQ-011 memory_cycle_width  in  2  0 byte, 1 word, 2 long, 3 illegal.
REQ-012 store_data  in  32  store value, right-justified.
REQ-013 alu_op  in  5; alu_reg2, alu_reg3  in  32 each; carry_in  in  1.
REQ-014 alu_result  out  32; carry_out, zero_out, neg_out, over_out  out  1 each; all registered.
REQ-015 agu_result  out  32  combinational effective address.
REQ-016 cpu_data_in  out  32  read data, right-justified, zero-extended.
REQ-017 address  out  30  bus long-word address, bits [31:2].
REQ-018 data_in  in  32; data_out  out  32; data_strobes  out  4, bit 3 = lane [31:24].
REQ-019 read, write, bus_error  out  1 each.

Function
REQ-020 The AGU SHALL output agu_result = base_address + (immediate_mode ? sign-extended immediate : register_data), modulo 2^32.
REQ-021 The effective cycle SHALL be: if memory_access_cycle=0, address = program_counter, width long, read=1, write=0, data out = 0; otherwise agu_result, memory_cycle_width, memory_read, memory_write, store_data.
REQ-022 address SHALL equal effective address bits [31:2].
REQ-023 Byte lanes SHALL be big-endian: long → strobes 1111; word at A[1]=0 → 1100, A[1]=1 → 0011; byte at A[1:0]=0,1,2,3 → 1000, 0100, 0010, 0001.
REQ-024 data_out SHALL place the store value's low byte/word in the selected lanes; all other bits are 0.
REQ-025 cpu_data_in SHALL be the selected lanes of data_in shifted to bit 0, zero-extended.
REQ-026 bus_error SHALL assert combinationally for a word with A[0]=1, a long with A[1:0]≠0, or width 3.
REQ-027 While bus_error=1: read=0, write=0, strobes=0000, data_out=0, cpu_data_in=0.
REQ-028 ALU ops: 00 ADD, 01 ADDC, 02 SUB, 03 SUBC, 04 AND, 05 OR, 06 XOR, 07 COPY(reg3), 08 NOT(reg3), 09 NEG(0−reg3), 0A LSL, 0B LSR, 0C ASR, 0D SEXB(reg3[7:0]), 0E SEXW(reg3[15:0]), 0F TEST(result reg3).
REQ-029 Shift ops SHALL shift reg2 by reg3[4:0].
REQ-030 ADDC SHALL add carry_in; SUBC SHALL subtract carry_in.
REQ-031 Unlisted ops (10–1F) SHALL produce result 0 with Z=1 and C=N=V=0.
REQ-032 Z SHALL be 1 when result=0; N SHALL be result[31].
REQ-033 Add ops: C = carry out of bit 31. Sub ops and NEG: C = borrow. V = two's-complement signed overflow.
REQ-034 Shifts: C = last bit shifted out (0 if count is 0); V=0. Logic, copy and sign-extend ops: C=0, V=0.
REQ-035 The ALU result and all four flags SHALL register on every rising edge with no enable: latency 1 cycle, all inputs sampled together.

Reset
REQ-036 While reset=1: alu_result=0 and all flags=0, asserted asynchronously.
REQ-037 Reset SHALL NOT affect the combinational AGU or bus paths.
REQ-038 An ALU operation in flight when reset asserts SHALL be discarded.

Verification
REQ-039 Fetch: memory_access_cycle=0, PC=0x00001004 → address=0x00000401, read=1, strobes=1111, bus_error=0.
REQ-040 AGU immediate: base=0x1000, imm=0xFFFC, mode=1 → agu_result=0x00000FFC.
REQ-041 Byte store: byte width, A=0x2002, store=0x000000AB → strobes=0010, data_out=0x0000AB00, write=1.
REQ-042 Word read: word width, A=0x3000, data_in=0x12345678 → cpu_data_in=0x00001234.
REQ-043 Misaligned long: long width, A=0x3002 → bus_error=1, read=0, write=0, strobes=0000.
REQ-044 ALU: ADD 0x7FFFFFFF+1 → next cycle result=0x80000000, N=1, V=1, C=0, Z=0. SUB 5−5 → Z=1, C=0.

Source files
------------

// File: rtl/exec_bus_if.sv
// Memory bus between the execution datapath (master) and the memory system (slave).
// Address is a long-word address; strobe bit 3 selects lane [31:24] (big-endian).
interface exec_bus_if;
  logic [29:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        bus_error;

  modport master (
    output address, data_out, data_strobes, read, write, bus_error,
    input  data_in
  );

  modport slave (
    input  address, data_out, data_strobes, read, write, bus_error,
    output data_in
  );
endinterface

// File: rtl/exec_datapath.sv
// Execution datapath: combinational AGU and big-endian bus lane steering,
// plus a single-cycle registered ALU with C/Z/N/V flags.
module exec_datapath (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         base_address_i,
  input  logic [15:0]         immediate_i,
  input  logic                immediate_mode_i,
  input  logic [31:0]         register_data_i,
  input  logic [31:0]         program_counter_i,
  input  logic                memory_access_cycle_i,
  input  logic                memory_read_i,
  input  logic                memory_write_i,
  input  logic [1:0]          memory_cycle_width_i,
  input  logic [31:0]         store_data_i,
  input  logic [4:0]          alu_op_i,
  input  logic [31:0]         alu_reg2_i,
  input  logic [31:0]         alu_reg3_i,
  input  logic                carry_in_i,
  output logic [31:0]         alu_result_o,
  output logic                carry_out_o,
  output logic                zero_out_o,
  output logic                neg_out_o,
  output logic                over_out_o,
  output logic [31:0]         agu_result_o,
  output logic [31:0]         cpu_data_in_o,
  exec_bus_if.master          bus
);

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_WORD = 2'd1;
  localparam logic [1:0] W_LONG = 2'd2;

  function automatic logic add_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                   input logic signed [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                   input logic signed [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  // AGU
  logic signed [31:0] imm_sext;
  assign imm_sext     = 32'(signed'(immediate_i));
  assign agu_result_o = base_address_i + (immediate_mode_i ? imm_sext : register_data_i);

  // Effective cycle: instruction fetch is always an aligned long read
  logic [31:0] ea;
  logic [1:0]  eff_width;
  logic        eff_rd, eff_wr;
  logic [31:0] eff_store;
  always_comb begin
    if (memory_access_cycle_i) begin
      ea        = agu_result_o;
      eff_width = memory_cycle_width_i;
      eff_rd    = memory_read_i;
      eff_wr    = memory_write_i;
      eff_store = store_data_i;
    end else begin
      ea        = program_counter_i;
      eff_width = W_LONG;
      eff_rd    = 1'b1;
      eff_wr    = 1'b0;
      eff_store = 32'd0;
    end
  end

  logic        misaligned;
  logic [3:0]  lanes;
  logic [31:0] lane_mask, store_rep, load_just;
  always_comb begin
    misaligned = 1'b0;
    lanes      = 4'b0000;
    store_rep  = 32'd0;
    load_just  = 32'd0;
    case (eff_width)
      W_BYTE: begin
        lanes     = 4'b1000 >> ea[1:0];
        store_rep = {4{eff_store[7:0]}};
        case (ea[1:0])
          2'd0:    load_just = {24'd0, bus.data_in[31:24]};
          2'd1:    load_just = {24'd0, bus.data_in[23:16]};
          2'd2:    load_just = {24'd0, bus.data_in[15:8]};
          default: load_just = {24'd0, bus.data_in[7:0]};
        endcase
      end
      W_WORD: begin
        misaligned = ea[0];
        lanes      = ea[1] ? 4'b0011 : 4'b1100;
        store_rep  = {2{eff_store[15:0]}};
        load_just  = ea[1] ? {16'd0, bus.data_in[15:0]} : {16'd0, bus.data_in[31:16]};
      end
      W_LONG: begin
        misaligned = (ea[1:0] != 2'd0);
        lanes      = 4'b1111;
        store_rep  = eff_store;
        load_just  = bus.data_in;
      end
      default: misaligned = 1'b1;
    endcase
    lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  end

  // A faulting cycle must not reach memory or the CPU in any form
  assign bus.address      = ea[31:2];
  assign bus.bus_error    = misaligned;
  assign bus.read         = eff_rd & ~misaligned;
  assign bus.write        = eff_wr & ~misaligned;
  assign bus.data_strobes = misaligned ? 4'b0000 : lanes;
  assign bus.data_out     = misaligned ? 32'd0 : (store_rep & lane_mask);
  assign cpu_data_in_o    = misaligned ? 32'd0 : load_just;

  // ALU, combinational next-state
  logic signed [31:0] a_s, b_s;
  logic [4:0]         sh;
  logic [31:0]        res_d;
  logic               c_d, v_d;
  assign a_s = alu_reg2_i;
  assign b_s = alu_reg3_i;
  assign sh  = alu_reg3_i[4:0];

  always_comb begin
    res_d = 32'd0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (alu_op_i)
      5'h00: begin
        {c_d, res_d} = {1'b0, a_s} + {1'b0, b_s};
        v_d = add_ovf(a_s, b_s, res_d);
      end
      5'h01: begin
        {c_d, res_d} = {1'b0, a_s} + {1'b0, b_s} + {32'd0, carry_in_i};
        v_d = add_ovf(a_s, b_s, res_d);
      end
      5'h02: begin
        {c_d, res_d} = {1'b0, a_s} - {1'b0, b_s};
        v_d = sub_ovf(a_s, b_s, res_d);
      end
      5'h03: begin
        {c_d, res_d} = {1'b0, a_s} - {1'b0, b_s} - {32'd0, carry_in_i};
        v_d = sub_ovf(a_s, b_s, res_d);
      end
      5'h04: res_d = a_s & b_s;
      5'h05: res_d = a_s | b_s;
      5'h06: res_d = a_s ^ b_s;
      5'h07: res_d = b_s;
      5'h08: res_d = ~b_s;
      5'h09: begin
        {c_d, res_d} = 33'd0 - {1'b0, b_s};
        v_d = sub_ovf(32'sd0, b_s, res_d);
      end
      // A guard bit beside the operand captures the last bit shifted out
      5'h0A: {c_d, res_d} = {1'b0, a_s} << sh;
      5'h0B: {res_d, c_d} = {a_s, 1'b0} >> sh;
      5'h0C: {res_d, c_d} = $signed({a_s, 1'b0}) >>> sh;
      5'h0D: res_d = {{24{b_s[7]}}, b_s[7:0]};
      5'h0E: res_d = {{16{b_s[15]}}, b_s[15:0]};
      5'h0F: res_d = b_s;
      default: res_d = 32'd0;
    endcase
  end

  // Stage boundary: ALU result and flags
  logic [31:0] alu_result_q;
  logic        c_q, z_q, n_q, v_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_result_q <= 32'd0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      n_q          <= 1'b0;
      v_q          <= 1'b0;
    end else begin
      alu_result_q <= res_d;
      c_q          <= c_d;
      z_q          <= (res_d == 32'd0);
      n_q          <= res_d[31];
      v_q          <= v_d;
    end
  end

  assign alu_result_o = alu_result_q;
  assign carry_out_o  = c_q;
  assign zero_out_o   = z_q;
  assign neg_out_o    = n_q;
  assign over_out_o   = v_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed-vector bench for exec_datapath: bus steering, AGU and registered ALU.
module tb_exec_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base_address, register_data, program_counter, store_data;
  logic [15:0] immediate;
  logic        immediate_mode, memory_access_cycle, memory_read, memory_write;
  logic [1:0]  memory_cycle_width;
  logic [4:0]  alu_op;
  logic [31:0] alu_reg2, alu_reg3;
  logic        carry_in;
  logic [31:0] alu_result, agu_result, cpu_data_in;
  logic        carry_out, zero_out, neg_out, over_out;

  int checks   = 0;
  int failures = 0;

  exec_bus_if bus ();

  exec_datapath dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .base_address_i        (base_address),
    .immediate_i           (immediate),
    .immediate_mode_i      (immediate_mode),
    .register_data_i       (register_data),
    .program_counter_i     (program_counter),
    .memory_access_cycle_i (memory_access_cycle),
    .memory_read_i         (memory_read),
    .memory_write_i        (memory_write),
    .memory_cycle_width_i  (memory_cycle_width),
    .store_data_i          (store_data),
    .alu_op_i              (alu_op),
    .alu_reg2_i            (alu_reg2),
    .alu_reg3_i            (alu_reg3),
    .carry_in_i            (carry_in),
    .alu_result_o          (alu_result),
    .carry_out_o           (carry_out),
    .zero_out_o            (zero_out),
    .neg_out_o             (neg_out),
    .over_out_o            (over_out),
    .agu_result_o          (agu_result),
    .cpu_data_in_o         (cpu_data_in),
    .bus                   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data access at absolute address a (immediate mode, zero displacement)
  task automatic data_cycle(input logic [31:0] a, input logic [1:0] w,
                            input logic rd, input logic wr, input logic [31:0] st);
    memory_access_cycle = 1'b1;
    base_address        = a;
    immediate           = 16'h0000;
    immediate_mode      = 1'b1;
    memory_cycle_width  = w;
    memory_read         = rd;
    memory_write        = wr;
    store_data          = st;
    #1;
  endtask

  // Apply one ALU op, wait one edge, check result and {C,Z,N,V}
  task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] r2,
                     input logic [31:0] r3, input logic ci,
                     input logic [31:0] exp_res, input logic [3:0] exp_czvn);
    alu_op   = op;
    alu_reg2 = r2;
    alu_reg3 = r3;
    carry_in = ci;
    @(posedge clk);
    #1;
    chk({tag, "_res"}, 64'(alu_result), 64'(exp_res));
    chk({tag, "_czvn"}, 64'({carry_out, zero_out, neg_out, over_out}), 64'(exp_czvn));
  endtask

  initial begin
    rst                 = 1'b1;
    base_address        = 32'd0;
    immediate           = 16'd0;
    immediate_mode      = 1'b0;
    register_data       = 32'd0;
    program_counter     = 32'd0;
    memory_access_cycle = 1'b0;
    memory_read         = 1'b0;
    memory_write        = 1'b0;
    memory_cycle_width  = 2'd0;
    store_data          = 32'd0;
    alu_op              = 5'h00;
    alu_reg2            = 32'h7FFF_FFFF;
    alu_reg3            = 32'h0000_0001;
    carry_in            = 1'b0;
    bus.data_in         = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", 64'(alu_result), 64'd0);
    chk("reset_flags", 64'({carry_out, zero_out, neg_out, over_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch
    program_counter = 32'h0000_1004;
    #1;
    chk("fetch_addr", 64'(bus.address), 64'h0000_0401);
    chk("fetch_rd_wr_err", 64'({bus.read, bus.write, bus.bus_error}), 64'b100);
    chk("fetch_strobes", 64'(bus.data_strobes), 64'hF);
    chk("fetch_dout", 64'(bus.data_out), 64'd0);

    // AGU
    base_address = 32'h0000_1000; immediate = 16'hFFFC; immediate_mode = 1'b1; #1;
    chk("agu_imm", 64'(agu_result), 64'h0000_0FFC);
    base_address = 32'h0000_0100; register_data = 32'h20; immediate_mode = 1'b0; #1;
    chk("agu_reg", 64'(agu_result), 64'h0000_0120);

    // Byte store at lane 2
    data_cycle(32'h0000_2002, 2'd0, 1'b0, 1'b1, 32'h0000_00AB);
    chk("bst_strobes", 64'(bus.data_strobes), 64'b0010);
    chk("bst_dout", 64'(bus.data_out), 64'h0000_AB00);
    chk("bst_wr", 64'({bus.read, bus.write, bus.bus_error}), 64'b010);
    chk("bst_addr", 64'(bus.address), 64'h0000_0800);

    // Reads
    data_cycle(32'h0000_3000, 2'd1, 1'b1, 1'b0, 32'd0);
    chk("wrd_hi", 64'(cpu_data_in), 64'h0000_1234);
    chk("wrd_hi_strb", 64'(bus.data_strobes), 64'b1100);
    data_cycle(32'h0000_3002, 2'd1, 1'b1, 1'b0, 32'd0);
    chk("wrd_lo", 64'(cpu_data_in), 64'h0000_5678);
    chk("wrd_lo_strb", 64'(bus.data_strobes), 64'b0011);
    data_cycle(32'h0000_3001, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("brd_1", 64'(cpu_data_in), 64'h0000_0034);
    chk("brd_1_strb", 64'(bus.data_strobes), 64'b0100);
    data_cycle(32'h0000_3003, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("brd_3", 64'(cpu_data_in), 64'h0000_0078);
    data_cycle(32'h0000_3000, 2'd2, 1'b1, 1'b0, 32'd0);
    chk("lrd", 64'(cpu_data_in), 64'h1234_5678);

    // Word store to low half
    data_cycle(32'h0000_3002, 2'd1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("wst_dout", 64'(bus.data_out), 64'h0000_BEEF);
    chk("wst_strb", 64'(bus.data_strobes), 64'b0011);

    // Bus errors
    data_cycle(32'h0000_3002, 2'd2, 1'b1, 1'b0, 32'd0);
    chk("mis_long", 64'({bus.bus_error, bus.read, bus.write}), 64'b100);
    chk("mis_long_strb", 64'(bus.data_strobes), 64'b0000);
    chk("mis_long_cdi", 64'(cpu_data_in), 64'd0);
    data_cycle(32'h0000_3001, 2'd1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("mis_word", 64'({bus.bus_error, bus.read, bus.write}), 64'b100);
    chk("mis_word_dout", 64'(bus.data_out), 64'd0);
    data_cycle(32'h0000_3000, 2'd3, 1'b1, 1'b0, 32'd0);
    chk("width3", 64'({bus.bus_error, bus.read, bus.data_strobes}), 64'b1_0_0000);

    // ALU; flag order {C,Z,N,V}
    @(negedge clk);
    alu("add_ovf",  5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011);
    alu("sub_zero", 5'h02, 32'd5,         32'd5,         1'b0, 32'h0000_0000, 4'b0100);
    alu("sub_brw",  5'h02, 32'd3,         32'd5,         1'b0, 32'hFFFF_FFFE, 4'b1010);
    alu("addc",     5'h01, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'h0000_0000, 4'b1100);
    alu("subc",     5'h03, 32'd16,        32'd3,         1'b1, 32'h0000_000C, 4'b0000);
    alu("lsl",      5'h0A, 32'h8000_0001, 32'd1,         1'b0, 32'h0000_0002, 4'b1000);
    alu("lsl0",     5'h0A, 32'h0000_0005, 32'd0,         1'b0, 32'h0000_0005, 4'b0000);
    alu("lsr",      5'h0B, 32'h0000_0003, 32'd1,         1'b0, 32'h0000_0001, 4'b1000);
    alu("asr",      5'h0C, 32'h8000_0000, 32'd4,         1'b0, 32'hF800_0000, 4'b0010);
    alu("neg1",     5'h09, 32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 4'b1010);
    alu("negmin",   5'h09, 32'd0,         32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1011);
    alu("sexb",     5'h0D, 32'd0,         32'h0000_0080, 1'b0, 32'hFFFF_FF80, 4'b0010);
    alu("xor",      5'h06, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0, 4'b0000);
    alu("unlisted", 5'h13, 32'h1234_5678, 32'h1,         1'b1, 32'h0000_0000, 4'b0100);

    // Async reset discards an operation already latched
    alu("pre_rst",  5'h07, 32'd0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_res", 64'(alu_result), 64'd0);
    chk("async_rst_flags", 64'({carry_out, zero_out, neg_out, over_out}), 64'd0);
    data_cycle(32'h0000_2002, 2'd0, 1'b0, 1'b1, 32'h0000_00AB);
    chk("rst_bus_path", 64'(bus.data_out), 64'h0000_AB00);
    @(negedge clk);
    rst = 1'b0;
    alu("post_rst", 5'h05, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00FF, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
